deserializer_100k: RTL and testbench
====================================

Name: deserializer_100k

Overview:
- Serial-to-parallel stage downstream of the clock divider; runs entirely on the 100 kHz divided clock.
- Accepts one qualified serial bit per cycle and assembles WIDTH-bit words.
- Presents each completed word to the 10 kHz-side queue logic and holds it until acknowledged.
- Exerts backpressure on the serial source through status_out while a word is pending.

Parameters:
- WIDTH, 8, bits per assembled word (2..16).
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clk_100KHz  input  1  sole clock, rising edge; driven by the clock divider's 100 kHz output.
- reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk_100KHz.
- data_in  input  1  serial data bit.
- write_in  input  1  data_in is valid this cycle.
- ack_in  input  1  consumer has taken data_out.
- data_out  output  WIDTH  assembled word; stable while data_ready=1.
- data_ready  output  1  data_out holds a complete, unacknowledged word.
- status_out  output  1  1 = not accepting bits (word pending); source must not write.

Behaviour:
- All outputs are registered.
- Reset values: data_out=0, data_ready=0, status_out=0, state=COLLECT, bit count=0, shift register=0.
- Reset is synchronous and overrides everything, including mid-word and HOLD:
  - the partial word is discarded;
  - a pending word is dropped without acknowledgment.
- COLLECT state (status_out=0, data_ready=0):
  - write_in=1: shift data_in into the shift register per MSB_FIRST and increment the count.
  - write_in=0: no change; gaps between bits are allowed and do not time out.
  - When the WIDTH-th bit is accepted at edge N, after edge N:
    - data_out = the assembled word;
    - data_ready = 1;
    - status_out = 1;
    - count = 0;
    - state = HOLD.
  - Latency: 0 extra cycles; the word is visible in the cycle after its last bit is sampled.
- HOLD state:
  - write_in is ignored; bits presented while status_out=1 are lost, which is a source protocol error.
  - data_out is frozen.
  - ack_in=1 sampled at edge M: after edge M, data_ready=0, status_out=0, state=COLLECT.
  - data_out keeps its last value after ack; it is not cleared.
  - First new bit can be accepted at edge M+1.
- ack_in=1 in COLLECT: ignored; the partial word is unaffected.
- ack_in and write_in both high in HOLD: ack takes effect, the write is ignored (status_out was 1 that cycle).
- ack_in held high continuously: each word is released one cycle after completion. Throughput is WIDTH bits per WIDTH+1 cycles minimum.
- Count width is clog2(WIDTH+1). The count never exceeds WIDTH-1 in COLLECT and wraps to 0 on word completion.
- Reset asserted in the same cycle as the final bit: reset wins; no word is produced.

Decomposition:
- Shared package deser_pkg:
  - state typedef enum logic {COLLECT, HOLD};
  - default WIDTH constant (8);
  - helper localparam for the count width.
- Single module. The shift register, counter and 2-state FSM are small enough that no sub-module is warranted.

Test Plan:
- Reset then bits 1,0,1,0,0,1,0,1 on consecutive cycles, MSB_FIRST=1:
  - data_ready=1 and status_out=1 one cycle after the 8th bit;
  - data_out=8'hA5 held until ack.
- Same bits with MSB_FIRST=0 -> data_out=8'hA5 bit-reversed = 8'hA5 (palindrome check); repeat with bits 1,1,0,0,0,0,0,0 -> 8'h03.
- Word 8'h3C pending; write_in pulsed 3 times with ack low -> data_out stays 8'h3C, bit count stays 0; after ack, next 8 bits 8'hFF -> 8'hFF.
- 8'h81 sent with 2-cycle gaps (write_in low) between bits -> data_out=8'h81; ack_in pulsed during COLLECT earlier has no effect.
- 5 bits sent, then reset for 1 cycle, then 8 bits 8'h5A -> data_out=8'h5A (no leftover bits); reset during HOLD -> data_ready=0, status_out=0 next cycle.
- ack_in tied high, back-to-back words 8'h01, 8'h02 -> each data_ready pulse is 1 cycle wide; second word completes 9 cycles after the first.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and constants for the 100 kHz serial-to-parallel stage.
package deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/deserializer_100k.sv
// Assembles qualified serial bits into WIDTH-bit words and holds each word
// until the consumer acknowledges it, backpressuring the source meanwhile.
module deserializer_100k
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_100KHz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             status_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               ready_q, ready_d;
  logic               status_q, status_d;
  logic [WIDTH-1:0]   shifted;

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ready_d  = ready_q;
    status_d = status_q;
    shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], data_in}
                         : {data_in, shift_q[WIDTH-1:1]};

    case (state_q)
      COLLECT: begin
        if (write_in) begin
          shift_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            data_d   = shifted;
            ready_d  = 1'b1;
            status_d = 1'b1;
            cnt_d    = '0;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // Writes here are a source protocol error and are dropped.
        if (ack_in) begin
          ready_d  = 1'b0;
          status_d = 1'b0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      status_q <= status_d;
    end
  end

  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_deserializer_100k.sv
// Bench for deserializer_100k: MSB-first and LSB-first instances driven in
// parallel, compared against a bit-list reference model every cycle.
module tb_deserializer_100k;

  localparam int unsigned W = 8;

  logic         clk_100KHz = 1'b0;
  logic         reset = 1'b0, data_in = 1'b0, write_in = 1'b0, ack_in = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic         rdy_m, rdy_l, stat_m, stat_l;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // reference model state
  bit           bits[$];
  logic         m_hold = 1'b0;
  logic [W-1:0] m_dm = '0, m_dl = '0;

  // ready-pulse tracking
  logic prev_rdy = 1'b0;
  int   rise_q[$];
  int   fall_q[$];

  typedef struct {
    logic         r, d, w, a;
    logic         exp_rdy;
    logic [W-1:0] exp_m, exp_l;
  } vec_t;

  vec_t tbl[12];

  always #5 clk_100KHz = ~clk_100KHz;

  deserializer_100k #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in),
    .write_in(write_in), .ack_in(ack_in), .data_out(dout_m),
    .data_ready(rdy_m), .status_out(stat_m));

  deserializer_100k #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in),
    .write_in(write_in), .ack_in(ack_in), .data_out(dout_l),
    .data_ready(rdy_l), .status_out(stat_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, ncyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic d, input logic w, input logic a);
    if (r) begin
      bits.delete();
      m_hold = 1'b0;
      m_dm   = '0;
      m_dl   = '0;
    end else if (m_hold) begin
      if (a) m_hold = 1'b0;
    end else if (w) begin
      bits.push_back(d);
      if (bits.size() == W) begin
        m_dm = '0;
        m_dl = '0;
        for (int i = 0; i < int'(W); i++) begin
          m_dm = m_dm | (W'(bits[i]) << (W - 1 - i));
          m_dl = m_dl | (W'(bits[i]) << i);
        end
        m_hold = 1'b1;
        bits.delete();
      end
    end
  endtask

  task automatic cyc(input logic r, input logic d, input logic w, input logic a);
    reset = r; data_in = d; write_in = w; ack_in = a;
    @(posedge clk_100KHz);
    model_step(r, d, w, a);
    #1;
    ncyc++;
    chk("model_rdy_m",  32'(rdy_m),  32'(m_hold));
    chk("model_stat_m", 32'(stat_m), 32'(m_hold));
    chk("model_data_m", 32'(dout_m), 32'(m_dm));
    chk("model_rdy_l",  32'(rdy_l),  32'(m_hold));
    chk("model_stat_l", 32'(stat_l), 32'(m_hold));
    chk("model_data_l", 32'(dout_l), 32'(m_dl));
    if (rdy_m && !prev_rdy) rise_q.push_back(ncyc);
    if (!rdy_m && prev_rdy) fall_q.push_back(ncyc);
    prev_rdy = rdy_m;
  endtask

  // Sends b[W-1] first, with optional idle gaps between bits.
  task automatic send_bits(input logic [W-1:0] b, input int gap, input logic gap_ack);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      cyc(1'b0, b[i], 1'b1, 1'b0);
      if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0, gap_ack);
    end
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] em, input logic [W-1:0] el);
    chk({name, "_rdy"},  32'(rdy_m),  32'd1);
    chk({name, "_stat"}, 32'(stat_l), 32'd1);
    chk({name, "_m"},    32'(dout_m), 32'(em));
    chk({name, "_l"},    32'(dout_l), 32'(el));
  endtask

  initial begin
    logic [W-1:0] a5 = 8'hA5;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, a5[8-i], 1'b1, 1'b0, (i == 8), (i == 8) ? 8'hA5 : 8'h00,
                 (i == 8) ? 8'hA5 : 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].d, tbl[i].w, tbl[i].a);
      chk($sformatf("tbl%0d_rdy", i),  32'(rdy_m),  32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_stat", i), 32'(stat_m), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_m", i),    32'(dout_m), 32'(tbl[i].exp_m));
      chk($sformatf("tbl%0d_l", i),    32'(dout_l), 32'(tbl[i].exp_l));
    end

    // first-bit ordering: 1,1,0,0,0,0,0,0
    send_bits(8'hC0, 0, 1'b0);
    chk_word("c0", 8'hC0, 8'h03);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // writes while pending are dropped
    send_bits(8'h3C, 0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_word("hold3c", 8'h3C, 8'h3C);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("ack_rdy", 32'(rdy_m), 32'd0);
    chk("ack_keep", 32'(dout_m), 32'h3C);
    send_bits(8'hFF, 0, 1'b0);
    chk_word("ff", 8'hFF, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // gaps between bits, ack pulses during collect
    send_bits(8'h81, 2, 1'b1);
    chk_word("gap81", 8'h81, 8'h81);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h5A, 0, 1'b0);
    chk_word("rst5a", 8'h5A, 8'h5A);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rsthold_rdy",  32'(rdy_m),  32'd0);
    chk("rsthold_stat", 32'(stat_l), 32'd0);
    chk("rsthold_data", 32'(dout_m), 32'd0);

    // reset in the same cycle as the final bit
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rstlast_rdy", 32'(rdy_l), 32'd0);

    // back-to-back with ack tied high
    rise_q.delete(); fall_q.delete();
    send_bits(8'h01, 0, 1'b1);
    ack_in = 1'b1;
    chk_word("b2b01", 8'h01, 8'h80);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      logic [W-1:0] w2 = 8'h02;
      cyc(1'b0, w2[i], 1'b1, 1'b1);
    end
    chk_word("b2b02", 8'h02, 8'h40);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_rises", 32'(rise_q.size()), 32'd2);
    chk("b2b_falls", 32'(fall_q.size()), 32'd2);
    if (rise_q.size() == 2 && fall_q.size() == 2) begin
      chk("b2b_width0",  32'(fall_q[0] - rise_q[0]), 32'd1);
      chk("b2b_width1",  32'(fall_q[1] - rise_q[1]), 32'd1);
      chk("b2b_spacing", 32'(rise_q[1] - rise_q[0]), 32'd9);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 200) == 0, 1'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
